uart_rx: RTL and testbench

- UART receiver that consumes the 16x-baud `clken` strobe from the baud rate generator and deserialises asynchronous serial input `rxd` into parallel characters.
- Sits on the receive side of the console/DZ-style UART, opposite the transmitter.
- Provides a one-deep holding register with a full/clear handshake, plus parity, framing and overrun error flags.

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive holding-register port of uart_rx: character, status flags
// and the consumer's clear strobe.
interface uart_rx_if;
    logic [7:0] data;
    logic       full;
    logic       pare;
    logic       frme;
    logic       ovre;
    logic       clr;

    modport master (
        output data, full, pare, frme, ovre,
        input  clr
    );

    modport slave (
        input  data, full, pare, frme, ovre,
        output clr
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5..8 data bits, optional parity,
// one-deep holding register with overrun detection.
module uart_rx #(
    parameter int SYNC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic [1:0] length,
    input  logic [1:0] parity,
    input  logic       rxd,
    uart_rx_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP
    } state_t;

    state_t          state, nxt;
    logic [SYNC-1:0] sync_q;
    logic            rxd_s;
    logic [3:0]      brcnt;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic [1:0]      len_q, par_q;
    logic            perr_q, exp_par;
    logic            mid, last;
    logic            go, arm, smp_d, smp_p, dlv;
    logic [7:0]      data_q;
    logic            full_q, pare_q, frme_q, ovre_q;

    assign rxd_s = sync_q[SYNC-1];
    assign mid   = brcnt == 4'd15;
    assign last  = bitcnt == ({1'b0, len_q} + 3'd4);

    always_ff @(posedge clk) begin
        if (!rst) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC-2:0], rxd};
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (clken) begin
            unique case (state)
                IDLE:  if (!rxd_s) nxt = START;
                START: if (brcnt == 4'd7) nxt = rxd_s ? IDLE : DATA;
                DATA:  if (mid && last) nxt = (par_q != 2'b00) ? PAR : STOP;
                PAR:   if (mid) nxt = STOP;
                STOP:  if (mid) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        go    = 1'b0;
        arm   = 1'b0;
        smp_d = 1'b0;
        smp_p = 1'b0;
        dlv   = 1'b0;
        if (clken) begin
            unique case (state)
                IDLE:  go    = !rxd_s;
                START: arm   = (brcnt == 4'd7) && !rxd_s;
                DATA:  smp_d = mid;
                PAR:   smp_p = mid;
                STOP:  dlv   = mid;
                default: ;
            endcase
        end
    end

    // shreg is cleared per character, so its XOR is the data-bit XOR
    always_comb begin
        unique case (par_q)
            2'b01:   exp_par = ~^shreg;
            2'b10:   exp_par = ^shreg;
            default: exp_par = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            brcnt  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            len_q  <= '0;
            par_q  <= '0;
            perr_q <= 1'b0;
        end else if (clken) begin
            if (go || arm)
                brcnt <= '0;
            else if (state != IDLE)
                brcnt <= brcnt + 4'd1;
            if (go) begin
                len_q <= length;
                par_q <= parity;
            end
            if (arm) begin
                bitcnt <= '0;
                shreg  <= '0;
                perr_q <= 1'b0;
            end
            if (smp_d) begin
                shreg <= {rxd_s, shreg[7:1]};
                if (!last) bitcnt <= bitcnt + 3'd1;
            end
            if (smp_p) perr_q <= rxd_s ^ exp_par;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            full_q <= 1'b0;
            pare_q <= 1'b0;
            frme_q <= 1'b0;
            ovre_q <= 1'b0;
        end else if (dlv) begin
            data_q <= shreg >> (3'd3 - {1'b0, len_q});
            pare_q <= perr_q;
            frme_q <= ~rxd_s;
            full_q <= 1'b1;
            ovre_q <= ~bus.clr & (ovre_q | full_q);
        end else if (bus.clr) begin
            full_q <= 1'b0;
            ovre_q <= 1'b0;
        end
    end

    assign bus.data = data_q;
    assign bus.full = full_q;
    assign bus.pare = pare_q;
    assign bus.frme = frme_q;
    assign bus.ovre = ovre_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: reset, table vectors, handshake corner cases and
// randomized frames against a frame-level reference model.
module tb_uart_rx;
    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       clken  = 1'b0;
    logic       rxd    = 1'b1;
    logic [1:0] length = 2'd0;
    logic [1:0] parity = 2'd0;
    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         ck_mode = 0;

    uart_rx_if bus();

    uart_rx #(.SYNC(2)) dut (
        .clk(clk), .rst(rst), .clken(clken), .length(length),
        .parity(parity), .rxd(rxd), .bus(bus)
    );

    always #5 clk = ~clk;

    // mode 0: clken tied high; mode 1: irregular strobe spacing
    always @(negedge clk)
        clken = (ck_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] len;
        logic [1:0] par;
        logic [7:0] chr;
        logic       pbit;
        logic       stop;
        logic [7:0] xd;
        logic       xp;
        logic       xf;
    } vec_t;

    typedef struct packed {
        logic       f;
        logic       p;
        logic [7:0] d;
    } exp_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!clken) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_ticks(16);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        wait_ticks(n);
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] len, input logic [1:0] par,
                              input logic [7:0] chr, input logic pbit,
                              input logic stop, input bit scramble);
        int nb;
        nb = int'(len) + 5;
        length = len;
        parity = par;
        send_bit(1'b0);
        if (scramble) begin
            length = 2'($urandom);
            parity = 2'($urandom);
        end
        for (int i = 0; i < nb; i++) send_bit(chr[i]);
        if (par != 2'd0) send_bit(pbit);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    function automatic exp_t model(input logic [1:0] len,
                                   input logic [1:0] par,
                                   input logic [7:0] chr,
                                   input logic pbit, input logic stop);
        exp_t r;
        int   nb, ones;
        logic want;
        nb   = int'(len) + 5;
        r.d  = chr & 8'((1 << nb) - 1);
        ones = $countones(r.d);
        case (par)
            2'd1:    want = (ones % 2) == 0;
            2'd2:    want = (ones % 2) == 1;
            default: want = 1'b1;
        endcase
        r.p = (par != 2'd0) && (pbit != want);
        r.f = !stop;
        return r;
    endfunction

    initial begin
        int   unread;
        bit   lost;
        exp_t m;
        logic [1:0] rl, rp;
        logic [7:0] rc;
        logic rb;

        tbl[0] = '{2'd0, 2'd2, 8'h13, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0};
        tbl[1] = '{2'd0, 2'd2, 8'h13, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0};
        tbl[2] = '{2'd3, 2'd0, 8'h41, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1};
        tbl[3] = '{2'd3, 2'd0, 8'h42, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0};
        tbl[4] = '{2'd1, 2'd1, 8'h2A, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0};
        tbl[5] = '{2'd2, 2'd3, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};
        tbl[6] = '{2'd1, 2'd0, 8'hFF, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0};
        tbl[7] = '{2'd3, 2'd1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

        bus.clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data", bus.data, 8'h00);
        chk("rst_full", 8'(bus.full), 8'h0);
        chk("rst_pare", 8'(bus.pare), 8'h0);
        chk("rst_frme", 8'(bus.frme), 8'h0);
        chk("rst_ovre", 8'(bus.ovre), 8'h0);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        chk("idle_full", 8'(bus.full), 8'h0);

        // full must rise exactly 155 clk after the start bit begins
        fork
            send_frame(2'd3, 2'd0, 8'hA5, 1'b0, 1'b1, 1'b0);
            begin
                repeat (154) @(negedge clk);
                chk("lat_pre", 8'(bus.full), 8'h0);
                @(negedge clk);
                chk("lat_full", 8'(bus.full), 8'h1);
            end
        join
        chk("a5_data", bus.data, 8'hA5);
        chk("a5_pare", 8'(bus.pare), 8'h0);
        chk("a5_frme", 8'(bus.frme), 8'h0);
        pulse_clr();
        chk("a5_clr", 8'(bus.full), 8'h0);
        idle(32);

        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].len, tbl[i].par, tbl[i].chr,
                       tbl[i].pbit, tbl[i].stop, 1'b0);
            chk($sformatf("v%0d_data", i), bus.data, tbl[i].xd);
            chk($sformatf("v%0d_pare", i), 8'(bus.pare), 8'(tbl[i].xp));
            chk($sformatf("v%0d_frme", i), 8'(bus.frme), 8'(tbl[i].xf));
            chk($sformatf("v%0d_full", i), 8'(bus.full), 8'h1);
            pulse_clr();
            chk($sformatf("v%0d_clr", i), 8'(bus.full), 8'h0);
            idle(32);
        end

        send_frame(2'd3, 2'd0, 8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(2'd3, 2'd0, 8'h22, 1'b0, 1'b1, 1'b0);
        chk("ovr_data", bus.data, 8'h22);
        chk("ovr_full", 8'(bus.full), 8'h1);
        chk("ovr_ovre", 8'(bus.ovre), 8'h1);
        pulse_clr();
        chk("ovr_clr", 8'(bus.ovre), 8'h0);
        idle(32);

        send_frame(2'd3, 2'd0, 8'h11, 1'b0, 1'b1, 1'b0);
        fork
            send_frame(2'd3, 2'd0, 8'h22, 1'b0, 1'b1, 1'b0);
            begin
                repeat (154) @(negedge clk);
                pulse_clr();
            end
        join
        chk("same_data", bus.data, 8'h22);
        chk("same_full", 8'(bus.full), 8'h1);
        chk("same_ovre", 8'(bus.ovre), 8'h0);
        pulse_clr();
        idle(32);

        rxd = 1'b0;
        repeat (6) @(negedge clk);
        rxd = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_full", 8'(bus.full), 8'h0);
        chk("glitch_data", bus.data, 8'h22);

        length = 2'd3;
        parity = 2'd0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b1 : (i != 0));
        rxd = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_data", bus.data, 8'h00);
        chk("mrst_full", 8'(bus.full), 8'h0);
        chk("mrst_flags", {5'd0, bus.pare, bus.frme, bus.ovre}, 8'h00);
        rst = 1'b1;
        idle(200);
        chk("mrst_nodlv", 8'(bus.full), 8'h0);
        send_frame(2'd3, 2'd0, 8'h7E, 1'b0, 1'b1, 1'b0);
        chk("mrst_next", bus.data, 8'h7E);
        chk("mrst_nfull", 8'(bus.full), 8'h1);
        pulse_clr();
        idle(32);

        unread = 0;
        lost   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            ck_mode = int'($urandom_range(0, 1));
            idle(4);
            rl = 2'($urandom);
            rp = 2'($urandom);
            rc = 8'($urandom);
            rb = 1'($urandom);
            send_frame(rl, rp, rc, rb, 1'b1, 1'b1);
            m = model(rl, rp, rc, rb, 1'b1);
            if (unread > 0) lost = 1'b1;
            unread = 1;
            chk($sformatf("r%0d_data", k), bus.data, m.d);
            chk($sformatf("r%0d_pare", k), 8'(bus.pare), 8'(m.p));
            chk($sformatf("r%0d_frme", k), 8'(bus.frme), 8'(m.f));
            chk($sformatf("r%0d_full", k), 8'(bus.full), 8'(unread));
            chk($sformatf("r%0d_ovre", k), 8'(bus.ovre), 8'(lost));
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                unread = 0;
                lost   = 1'b0;
            end
            idle(int'($urandom_range(8, 20)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
